// File: rtl/sprite_renderer.sv
// Pixel-colour stage: square sprite over a background, x moved by debounced buttons, y bounces per frame.
// Optional 32-px grid on the background when GRID_OVERLAY_EN is defined.
module sprite_renderer #(
    parameter int          H_RES     = 800,
    parameter int          V_RES     = 600,
    parameter int          SPR_SIZE  = 32,
    parameter int          STEP      = 4,
    parameter int          DB_CYCLES = 400000,
    parameter logic [23:0] BG_RGB    = 24'h101040
) (
    input  logic        i_pix_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_sx,
    input  logic [15:0] i_sy,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [2:0]  i_btn,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de
);

    localparam int CW = ($clog2(DB_CYCLES) < 1) ? 1 : $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);
    localparam logic [15:0] X_MAX  = 16'(H_RES - SPR_SIZE);
    localparam logic [15:0] X_INIT = 16'((H_RES - SPR_SIZE) / 2);
    localparam logic [15:0] Y_MAX  = 16'(V_RES - SPR_SIZE);
    localparam logic [15:0] STEP16 = 16'(STEP);
    localparam logic signed [16:0] H_LIM = 17'(H_RES);
    localparam logic signed [16:0] V_LIM = 17'(V_RES);
    localparam logic signed [16:0] SZ17  = 17'(SPR_SIZE);

    typedef enum logic {DOWN, UP} y_state_t;

    logic [2:0]    btn_s1, btn_s2, btn_db;
    logic [CW-1:0] db_cnt [3];
    logic          vs_prev, db2_prev, frame_tick;
    logic [15:0]   spr_x, spr_y, x_next, y_next;
    logic [16:0]   x_dec, x_inc, y_inc;
    logic [1:0]    colour_idx;
    y_state_t      y_state, y_next_state;
    logic [23:0]   pix_rgb, spr_rgb, bg_rgb;
    logic signed [16:0] sx_e, sy_e, spr_xe, spr_ye;
    logic          active, in_spr;

    // Button synchroniser and per-bit debounce
    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_db <= '0;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            btn_s1 <= i_btn;
            btn_s2 <= btn_s1;
            for (int unsigned i = 0; i < 3; i++) begin
                if (btn_s2[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    btn_db[i] <= btn_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign frame_tick = i_vs & ~vs_prev;

    // X motion: one bit of headroom makes underflow/overflow visible before clamping
    assign x_dec = {1'b0, spr_x} - {1'b0, STEP16};
    assign x_inc = {1'b0, spr_x} + {1'b0, STEP16};
    assign y_inc = {1'b0, spr_y} + {1'b0, STEP16};

    always_comb begin
        x_next = spr_x;
        if (btn_db[0] && !btn_db[1])
            x_next = x_dec[16] ? '0 : x_dec[15:0];
        else if (btn_db[1] && !btn_db[0])
            x_next = (x_inc > {1'b0, X_MAX}) ? X_MAX : x_inc[15:0];
    end

    // Y FSM: state register, next-state, output
    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            y_state <= DOWN;
            spr_x   <= X_INIT;
            spr_y   <= '0;
            vs_prev <= 1'b0;
        end else begin
            vs_prev <= i_vs;
            if (frame_tick) begin
                y_state <= y_next_state;
                spr_x   <= x_next;
                spr_y   <= y_next;
            end
        end
    end

    always_comb begin
        y_next_state = y_state;
        case (y_state)
            DOWN: if (y_inc >= {1'b0, Y_MAX}) y_next_state = UP;
            UP:   if (spr_y <= STEP16)        y_next_state = DOWN;
            default: y_next_state = DOWN;
        endcase
    end

    always_comb begin
        y_next = spr_y;
        case (y_state)
            DOWN: y_next = (y_inc >= {1'b0, Y_MAX}) ? Y_MAX : y_inc[15:0];
            UP:   y_next = (spr_y <= STEP16) ? '0 : spr_y - STEP16;
            default: y_next = spr_y;
        endcase
    end

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            db2_prev   <= 1'b0;
            colour_idx <= '0;
        end else begin
            db2_prev <= btn_db[2];
            if (btn_db[2] && !db2_prev) colour_idx <= colour_idx + 1'b1;
        end
    end

    always_comb begin
        case (colour_idx)
            2'd0:    spr_rgb = 24'hFF0000;
            2'd1:    spr_rgb = 24'h00FF00;
            2'd2:    spr_rgb = 24'h0000FF;
            default: spr_rgb = 24'hFFFFFF;
        endcase
    end

`ifdef GRID_OVERLAY_EN
    assign bg_rgb = (i_sx[4:0] == 5'd0 || i_sy[4:0] == 5'd0) ? 24'h404040 : BG_RGB;
`else
    assign bg_rgb = BG_RGB;
`endif

    assign sx_e   = {i_sx[15], i_sx};
    assign sy_e   = {i_sy[15], i_sy};
    assign spr_xe = {1'b0, spr_x};
    assign spr_ye = {1'b0, spr_y};
    assign active = !sx_e[16] && !sy_e[16] && (sx_e < H_LIM) && (sy_e < V_LIM);
    assign in_spr = (sx_e >= spr_xe) && (sx_e < spr_xe + SZ17) &&
                    (sy_e >= spr_ye) && (sy_e < spr_ye + SZ17);

    always_comb begin
        pix_rgb = '0;
        if (active) pix_rgb = in_spr ? spr_rgb : bg_rgb;
    end

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            {o_red, o_green, o_blue} <= '0;
            o_hs <= 1'b0;
            o_vs <= 1'b0;
            o_de <= 1'b0;
        end else begin
            {o_red, o_green, o_blue} <= pix_rgb;
            o_hs <= i_hs;
            o_vs <= i_vs;
            o_de <= i_de;
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer with a queue-based pixel scoreboard and a small position model.
module tb_sprite_renderer;

    logic        i_pix_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [15:0] i_sx = '0, i_sy = '0;
    logic        i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
    logic [2:0]  i_btn = '0;
    logic [7:0]  o_red, o_green, o_blue;
    logic        o_hs, o_vs, o_de;

    always #5 i_pix_clk = ~i_pix_clk;

    sprite_renderer #(.DB_CYCLES(4)) dut (
        .i_pix_clk(i_pix_clk), .i_rst_n(i_rst_n),
        .i_sx(i_sx), .i_sy(i_sy), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
        .i_btn(i_btn),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de)
    );

    int n_cmp = 0, n_fail = 0;
    logic [26:0] sb[$];
    int mx = 384, my = 0, midx = 0;
    bit mdown = 1'b1;

    function automatic logic [23:0] exp_pix(int sx, int sy);
        logic [23:0] pal [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
        if (sx < 0 || sy < 0 || sx >= 800 || sy >= 600) return 24'h0;
        if (sx >= mx && sx < mx + 32 && sy >= my && sy < my + 32) return pal[midx];
`ifdef GRID_OVERLAY_EN
        if (sx % 32 == 0 || sy % 32 == 0) return 24'h404040;
`endif
        return 24'h101040;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [26:0] e;
        @(posedge i_pix_clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pix", {5'd0, o_hs, o_vs, o_de, o_red, o_green, o_blue}, {5'd0, e});
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pix(int sx, int sy, bit de, bit hs);
        i_sx = 16'(sx);
        i_sy = 16'(sy);
        i_de = de;
        i_hs = hs;
        sb.push_back({hs, i_vs, de, exp_pix(sx, sy)});
        cycle();
    endtask

    task automatic frame();
        bit l, r;
        l = i_btn[0] && !i_btn[1];
        r = i_btn[1] && !i_btn[0];
        i_vs = 1'b1;
        cycle();
        if (l) mx = (mx >= 4) ? mx - 4 : 0;
        else if (r) mx = (mx + 4 > 768) ? 768 : mx + 4;
        if (mdown) begin
            if (my + 4 >= 568) begin my = 568; mdown = 1'b0; end
            else my = my + 4;
        end else begin
            if (my <= 4) begin my = 0; mdown = 1'b1; end
            else my = my - 4;
        end
        i_vs = 1'b0;
        cycle();
        check("spr_x", 32'(dut.spr_x), 32'(mx));
        check("spr_y", 32'(dut.spr_y), 32'(my));
        pix(mx, my, 1'b1, 1'b0);
        pix(mx - 1, my + 31, 1'b1, 1'b1);
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_out", {26'd0, o_hs, o_vs, o_de, |{o_red, o_green, o_blue}}, 32'd0);
        check("rst_x", 32'(dut.spr_x), 32'd384);
        check("rst_y", 32'(dut.spr_y), 32'd0);
        @(posedge i_pix_clk);
        #1 i_rst_n = 1'b1;

        // Line scan across the sprite row plus off-screen edges
        for (int sx = 0; sx < 800; sx++) pix(sx, 10, 1'b1, sx[0]);
        for (int sx = 380; sx < 420; sx++) pix(sx, 300, 1'b1, 1'b0);
        pix(-1, 10, 1'b0, 1'b0);
        pix(800, 10, 1'b0, 1'b1);
        pix(384, -5, 1'b0, 1'b0);
        pix(384, 600, 1'b0, 1'b0);
        pix(799, 599, 1'b1, 1'b0);
        pix(415, 31, 1'b1, 1'b0);
        pix(416, 32, 1'b1, 1'b0);

        // Move left to the clamp and hold there
        i_btn = 3'b001;
        idle(10);
        for (int f = 0; f < 100; f++) frame();
        check("x_clamp0", 32'(dut.spr_x), 32'd0);

        // Both buttons: no x motion
        i_btn = 3'b011;
        idle(10);
        for (int f = 0; f < 5; f++) frame();
        i_btn = 3'b000;
        idle(10);

        // Keep bouncing past the bottom turn and back up
        for (int f = 0; f < 95; f++) frame();

        // Colour: short glitch ignored, then four clean presses
        i_btn = 3'b100;
        idle(2);
        i_btn = 3'b000;
        idle(10);
        pix(mx, my, 1'b1, 1'b0);
        for (int p = 0; p < 4; p++) begin
            i_btn = 3'b100;
            idle(10);
            i_btn = 3'b000;
            idle(10);
            midx = (midx + 1) % 4;
            pix(mx + 5, my + 5, 1'b1, 1'b0);
        end
        check("idx_wrap", 32'(dut.colour_idx), 32'd0);

        // Grid / background directed pair
        pix(64, 10, 1'b1, 1'b0);
        pix(65, 10, 1'b1, 1'b0);

        // Asynchronous reset mid-frame
        i_btn = 3'b010;
        idle(10);
        for (int f = 0; f < 3; f++) frame();
        i_sx = 16'(mx);
        i_sy = 16'(my);
        i_de = 1'b1;
        i_hs = 1'b1;
        @(posedge i_pix_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_out", {26'd0, o_hs, o_vs, o_de, |{o_red, o_green, o_blue}}, 32'd0);
        check("arst_x", 32'(dut.spr_x), 32'd384);
        check("arst_y", 32'(dut.spr_y), 32'd0);
        i_btn = 3'b000;
        mx = 384; my = 0; mdown = 1'b1; midx = 0;
        @(posedge i_pix_clk);
        #1 i_rst_n = 1'b1;
        idle(10);
        for (int f = 0; f < 3; f++) frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
